mem_port_arbiter: RTL and testbench

- Sequences the single-port unified instruction/data memory of the RISC processor between two requesters: the fetch stage (IF, read-only) and the memory stage (DM, read/write).
- Grants one access at a time, drives the memory port, returns read data with a one-cycle grant pulse, and raises stall signals to the pipeline while a request is waiting.
- Sits between the pipeline (fetch and memory stages) and the memory macro, inside Processor.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-macro signals around mem_port_arbiter.
// The slave modport is the arbiter's view. The master modport is the pipeline and memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_fetch;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rdata, dm_gnt, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               stall_fetch, stall_mem
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rdata, dm_gnt, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               stall_fetch, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the unified single-port memory between fetch (IF) and memory stage (DM); DM wins ties.
// Optional IF anti-starvation guard: define ARB_STARVE_GUARD_EN.
//   state  | meaning
//   IDLE   | waiting for a request; arbitrate and latch owner/addr/we/wdata
//   ACCESS | memory port driven; count down MEM_LAT, capture read data on count 1
//   RESP   | one-cycle gnt to the owner, then back to IDLE (bubble cycle)
module mem_port_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_param_chk
        $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be >= 1");
    end

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_gnt_q, if_gnt_d;
    logic              dm_gnt_q, dm_gnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              pick_dm;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] starve_q, starve_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        pick_dm     = bus.dm_req;
`ifdef ARB_STARVE_GUARD_EN
        starve_d    = starve_q;
        // IF has waited through STARVE_MAX DM grants: it wins this round
        if (bus.if_req && starve_q == STARVE_W'(STARVE_MAX)) pick_dm = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    owner_d     = pick_dm;
                    we_d        = pick_dm & bus.dm_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = pick_dm & bus.dm_we;
                    mem_addr_d  = pick_dm ? bus.dm_addr : bus.if_addr;
                    mem_wdata_d = pick_dm ? bus.dm_wdata : mem_wdata_q;
                    cnt_d       = CNT_W'(MEM_LAT);
                    state_d     = S_ACCESS;
`ifdef ARB_STARVE_GUARD_EN
                    starve_d    = (pick_dm && bus.if_req) ? starve_q + STARVE_W'(1) : '0;
`endif
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (!owner_q)   if_rdata_d = bus.mem_rdata;
                    else if (!we_q) dm_rdata_d = bus.mem_rdata;
                    if_gnt_d = ~owner_q;
                    dm_gnt_d = owner_q;
                    state_d  = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
`ifdef ARB_STARVE_GUARD_EN
            starve_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q    <= starve_d;
`endif
        end
    end

    assign bus.if_gnt      = if_gnt_q;
    assign bus.dm_gnt      = dm_gnt_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.dm_rdata    = dm_rdata_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.stall_fetch = bus.if_req & ~if_gnt_q;
    assign bus.stall_mem   = bus.dm_req & ~dm_gnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=3.
// Starvation expectations follow ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    mem_port_arbiter_if #(.ADDR_W(20), .DATA_W(16)) b1();
    mem_port_arbiter_if #(.ADDR_W(20), .DATA_W(16)) b3();

    mem_port_arbiter #(.ADDR_W(20), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(4))
        u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    mem_port_arbiter #(.ADDR_W(20), .DATA_W(16), .MEM_LAT(3), .STARVE_MAX(4))
        u_dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

    always #5 clk = ~clk;

    // memory model: data is valid only in the cycle the arbiter is meant to sample it
    logic [15:0] mem_m [512];
    logic [2:0]  age3 = '0;
    always @(posedge clk) begin
        if (!rst) begin
            mem_m[9'h010] <= 16'hA5A5;
            mem_m[9'h040] <= 16'h4040;
            mem_m[9'h1FE] <= 16'h0000;
            mem_m[9'h100] <= 16'h0000;
            mem_m[9'h000] <= 16'hBEEF;
        end else if (b1.mem_en && b1.mem_we) begin
            mem_m[b1.mem_addr[8:0]] <= b1.mem_wdata;
        end
        age3 <= b3.mem_en ? 3'd1 : ((age3 != 3'd0 && age3 != 3'd7) ? age3 + 3'd1 : age3);
    end
    assign b1.mem_rdata = b1.mem_en ? mem_m[b1.mem_addr[8:0]] : 16'hDEAD;
    assign b3.mem_rdata = (age3 == 3'd2) ? mem_m[b3.mem_addr[8:0]] : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic dm_xfer(input logic we, input logic [19:0] a, input logic [15:0] d,
                           input string tag, output logic [15:0] rd);
        int n;
        step();
        b1.dm_req = 1'b1; b1.dm_we = we; b1.dm_addr = a; b1.dm_wdata = d;
        n = 0;
        do begin
            smp();
            n++;
        end while (!b1.dm_gnt && n < 10);
        chk({tag, "_gnt"}, b1.dm_gnt, 1);
        rd = b1.dm_rdata;
        step();
        b1.dm_req = 1'b0; b1.dm_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        int ng, ifc, cyc;
        logic exp_if;
        b1.if_req = 0; b1.if_addr = '0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = '0; b1.dm_wdata = '0;
        b3.if_req = 0; b3.if_addr = '0; b3.dm_req = 0; b3.dm_we = 0; b3.dm_addr = '0; b3.dm_wdata = '0;
        repeat (3) @(posedge clk);
        smp();
        chk("rst_ctl", {b1.if_gnt, b1.dm_gnt, b1.mem_en, b1.mem_we}, 0);
        chk("rst_addr", b1.mem_addr, 0);
        chk("rst_rdata", {b1.if_rdata, b1.dm_rdata}, 0);
        rst = 1'b1;

        // reset in the middle of an ACCESS
        step(); b1.dm_req = 1; b1.dm_we = 0; b1.dm_addr = 20'h00040;
        smp();
        step(); smp();
        chk("rmo_en", b1.mem_en, 1);
        chk("rmo_addr", b1.mem_addr, 20'h00040);
        #2 rst = 1'b0;
        #1;
        chk("rmo_ctl0", {b1.if_gnt, b1.dm_gnt, b1.mem_en, b1.mem_we}, 0);
        chk("rmo_addr0", b1.mem_addr, 0);
        chk("rmo_wdata0", b1.mem_wdata, 0);
        b1.dm_req = 0;
        smp(); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("rmo_quiet", {b1.if_gnt, b1.dm_gnt, b1.mem_en}, 0);
        end
        chk("rmo_rdata", b1.dm_rdata, 0);

        // single fetch
        step(); b1.if_req = 1; b1.if_addr = 20'h00010;
        smp();
        chk("sf_stall_t", b1.stall_fetch, 1);
        chk("sf_en_t", b1.mem_en, 0);
        step(); smp();
        chk("sf_en_t1", {b1.mem_en, b1.mem_we}, 2'b10);
        chk("sf_addr_t1", b1.mem_addr, 20'h00010);
        chk("sf_stall_t1", b1.stall_fetch, 1);
        chk("sf_gnt_t1", b1.if_gnt, 0);
        step(); smp();
        chk("sf_gnt_t2", {b1.if_gnt, b1.dm_gnt}, 2'b10);
        chk("sf_rdata", b1.if_rdata, 16'hA5A5);
        chk("sf_stall_t2", b1.stall_fetch, 0);
        step(); b1.if_req = 0;
        smp();
        chk("sf_gnt_t3", {b1.if_gnt, b1.mem_en}, 0);

        // simultaneous requests: DM write first, then IF
        step();
        b1.if_req = 1; b1.if_addr = 20'h00010;
        b1.dm_req = 1; b1.dm_we = 1; b1.dm_addr = 20'h0FFFE; b1.dm_wdata = 16'h1234;
        smp();
        step(); smp();
        chk("sim_en_t1", {b1.mem_en, b1.mem_we}, 2'b11);
        chk("sim_addr_t1", b1.mem_addr, 20'h0FFFE);
        chk("sim_wdata_t1", b1.mem_wdata, 16'h1234);
        chk("sim_stall_t1", {b1.stall_fetch, b1.stall_mem}, 2'b11);
        step(); smp();
        chk("sim_gnt_t2", {b1.if_gnt, b1.dm_gnt}, 2'b01);
        chk("sim_stall_t2", {b1.stall_fetch, b1.stall_mem}, 2'b10);
        chk("sim_wr_hold", b1.dm_rdata, 0);
        step(); b1.dm_req = 0; b1.dm_we = 0;
        smp();
        chk("sim_t3", {b1.mem_en, b1.if_gnt, b1.dm_gnt}, 0);
        step(); smp();
        chk("sim_en_t4", {b1.mem_en, b1.mem_we}, 2'b10);
        chk("sim_addr_t4", b1.mem_addr, 20'h00010);
        step(); smp();
        chk("sim_gnt_t5", {b1.if_gnt, b1.dm_gnt}, 2'b10);
        step(); b1.if_req = 0;
        smp();

        // MEM_LAT = 3 read
        step(); b3.dm_req = 1; b3.dm_we = 0; b3.dm_addr = 20'h00200;
        smp();
        chk("l3_stall_t", b3.stall_mem, 1);
        step(); smp();
        chk("l3_en_t1", b3.mem_en, 1);
        chk("l3_addr_t1", b3.mem_addr, 20'h00200);
        step(); smp();
        chk("l3_t2", {b3.mem_en, b3.dm_gnt}, 0);
        chk("l3_addr_t2", b3.mem_addr, 20'h00200);
        step(); smp();
        chk("l3_t3", {b3.mem_en, b3.dm_gnt}, 0);
        step(); smp();
        chk("l3_gnt_t4", {b3.if_gnt, b3.dm_gnt}, 2'b01);
        chk("l3_rdata", b3.dm_rdata, 16'hBEEF);
        step(); b3.dm_req = 0;
        smp();
        chk("l3_gnt_t5", b3.dm_gnt, 0);

        // write then read back
        dm_xfer(1, 20'h00100, 16'h5A5A, "wr1", rd);
        chk("wr1_hold", rd, 0);
        dm_xfer(0, 20'h00100, 16'h0000, "rd1", rd);
        chk("rd1_rdata", rd, 16'h5A5A);
        dm_xfer(1, 20'h00100, 16'h7777, "wr2", rd);
        chk("wr2_hold", rd, 16'h5A5A);
        dm_xfer(0, 20'h00100, 16'h0000, "rd2", rd);
        chk("rd2_rdata", rd, 16'h7777);
        chk("wr_if_unch", b1.if_rdata, 16'hA5A5);

        // both requesters held high for 20 accesses
        step();
        b1.if_req = 1; b1.if_addr = 20'h00010;
        b1.dm_req = 1; b1.dm_we = 0; b1.dm_addr = 20'h00040;
        ng = 0; ifc = 0; cyc = 0;
        while (ng < 20 && cyc < 200) begin
            smp();
            cyc++;
            if (b1.if_gnt || b1.dm_gnt) begin
`ifdef ARB_STARVE_GUARD_EN
                exp_if = (ng % 5 == 4);
`else
                exp_if = 1'b0;
`endif
                chk($sformatf("starve_seq%0d", ng), {b1.if_gnt, b1.dm_gnt}, {exp_if, ~exp_if});
                if (b1.if_gnt) ifc++;
                ng++;
            end
        end
        chk("starve_count", ng, 20);
`ifdef ARB_STARVE_GUARD_EN
        chk("starve_if_total", ifc, 4);
`else
        chk("starve_if_total", ifc, 0);
`endif
        step(); b1.if_req = 0; b1.dm_req = 0;
        smp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
